// File: rtl/param_arb_mux_pkg.sv
// Shared constants, FSM state type and round-robin index helper for the arbitrating mux.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default width/count constants, arb_state_e, rr_next().
package arb_mux_pkg;

  localparam int ARB_MUX_W = 32;
  localparam int ARB_MUX_N = 4;

  // ST_LOCK means a packet is mid-flight and the grant is pinned to last_grant.
  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // Next channel index in round-robin order, wrapping n-1 -> 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/param_arb_mux_if.sv
// Handshake bundle between N request channels, the arbitrating mux and its single output.
// Latency: n/a (wires only).
// Backpressure: in_ready grants per channel, out_ready stalls the output register.
// Ports: in_valid/in_data/in_last/in_ready (input side), out_valid/out_data/out_sel/out_last/out_ready (output side).
// Modports: master drives requests and out_ready; slave is the mux.
interface param_arb_mux_if
  import arb_mux_pkg::*;
#(
  parameter int W = ARB_MUX_W,
  parameter int N = ARB_MUX_N
);
  localparam int SELW = $clog2(N);

  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_sel;
  logic            out_last;
  logic            out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );

endinterface

// File: rtl/param_arb_mux_rr_pick.sv
// Round-robin priority pick: first requesting index strictly after last_grant, wrapping.
// Latency: combinational.
// Backpressure: none; the caller gates the one-hot grant.
// Ports: req (N requests), last_grant (SELW index), grant (one-hot or zero).
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter int N = ARB_MUX_N,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last_grant,
  output logic [N-1:0]    grant
);

  logic [SELW-1:0] idx;
  logic            found;

  // Walk N candidates starting just after last_grant; the first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = SELW'(rr_next(32'(last_grant), N));
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
      idx = SELW'(rr_next(32'(idx), N));
    end
  end

endmodule

// File: rtl/param_arb_mux.sv
// Round-robin N:1 arbitrating mux with a single registered output stage.
// Latency: one cycle from input accept to out_data/out_sel/out_last; one beat per cycle sustained.
// Backpressure: in_ready is zero while the output register is full and out_ready is low.
// Ports: clk, rst_n (async active-low), bus (param_arb_mux_if.slave).
// Config: define ARB_MUX_PKT_LOCK_EN to hold the grant on one channel from first beat until its in_last beat.
module param_arb_mux
  import arb_mux_pkg::*;
#(
  parameter int W = ARB_MUX_W,
  parameter int N = ARB_MUX_N,
  localparam int SELW = $clog2(N)
) (
  input logic             clk,
  input logic             rst_n,
  param_arb_mux_if.slave  bus
);

  arb_state_e      state_q, state_d;
  logic [SELW-1:0] last_grant;
  logic [N-1:0]    rr_grant;
  logic [N-1:0]    grant;
  logic [N-1:0]    ready;
  logic            can_load;
  logic            accept;
  logic [SELW-1:0] acc_idx;
  logic [W-1:0]    acc_data;
  logic            acc_last;

  logic            out_valid_q;
  logic [W-1:0]    out_data_q;
  logic [SELW-1:0] out_sel_q;
  logic            out_last_q;

  rr_pick #(.N(N)) u_rr_pick (
    .req        (bus.in_valid),
    .last_grant (last_grant),
    .grant      (rr_grant)
  );

  // Output register can take a beat if empty or being drained this edge.
  // Only registered out_valid feeds this, so there is no loop through in_valid.
  assign can_load = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ARB;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = rr_grant;
    // While locked only the channel owning the packet may be granted,
    // and nobody is granted if it pauses.
    if (state_q == ST_LOCK) begin
      grant             = '0;
      grant[last_grant] = bus.in_valid[last_grant];
    end
    ready = (rst_n && can_load) ? grant : '0;
`ifdef ARB_MUX_PKT_LOCK_EN
    if (accept) state_d = acc_last ? ST_ARB : ST_LOCK;
`else
    state_d = ST_ARB;
`endif
  end

  // ready is one-hot or zero, so a priority-free OR-scan selects the beat.
  always_comb begin
    acc_idx  = '0;
    acc_data = '0;
    acc_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ready[i]) begin
        acc_idx  = SELW'(i);
        acc_data = bus.in_data[i*W +: W];
        acc_last = bus.in_last[i];
      end
    end
  end

  assign accept = |ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      last_grant  <= SELW'(N - 1);
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= acc_data;
      out_sel_q   <= acc_idx;
      out_last_q  <= acc_last;
      last_grant  <= acc_idx;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: doc/param_arb_mux.md
PARAM_ARB_MUX -- requirements
Module: param_arb_mux

Interface
REQ-001 SHALL have parameter W, default 32, meaning the data width per channel in bits.
REQ-002 SHALL have parameter N, default 4, meaning the number of input channels, with N >= 2.
REQ-003 SHALL have derived parameter SELW, default $clog2(N), meaning the select index width; it is not user-overridable.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  N  per-channel request; bit i belongs to channel i.
REQ-007 in_data  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
REQ-008 in_last  input  N  per-channel end-of-packet marker, sampled with the beat.
REQ-009 in_ready  output  N  one-hot or zero grant/accept, combinational.
REQ-010 out_valid  output  1  output register holds a beat.
REQ-011 out_data  output  W  registered selected data.
REQ-012 out_sel  output  SELW  index of the channel that supplied out_data.
REQ-013 out_last  output  1  registered copy of the accepted in_last.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 SHALL transfer an input beat on channel i when in_valid[i] && in_ready[i] at a rising edge.
REQ-016 SHALL transfer an output beat when out_valid && out_ready at a rising edge.
REQ-017 SHALL assert at most one in_ready bit per cycle, and only when the output register is empty or is being drained in the same cycle (out_ready=1).
REQ-018 SHALL choose the granted channel round-robin: the first requesting index strictly after last_grant, wrapping N-1 -> 0.
REQ-019 SHALL give a one-cycle latency: data accepted at edge k appears on out_data/out_sel/out_last after edge k and remains stable until accepted.
REQ-020 SHALL update last_grant only on an accepted input beat.
REQ-021 SHALL sustain full throughput: one beat per cycle when out_ready is held at 1.
REQ-022 SHALL drive all in_ready bits to 0 when no in_valid bit is set, and leave the output register unchanged (cleared out_valid if it drained).
REQ-023 SHALL hold out_data, out_sel and out_last unchanged while out_valid && !out_ready.
REQ-024 SHALL make in_ready independent of in_data and must not depend combinationally on out_valid of the same beat being loaded (no loops).
REQ-025 SHALL perform a simultaneous drain and load in the same edge, loading the new beat and keeping out_valid=1.

Reset
REQ-026 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_sel=0, out_last=0, in_ready=0, last_grant=N-1, and lock=0.
REQ-027 SHALL discard an in-flight output beat on reset mid-operation; the first grant after release is channel 0 if it requests.

Configuration
REQ-028 SHALL, with ARB_MUX_PKT_LOCK_EN defined, hold the grant on the locked channel after an accepted beat with in_last=0 until that channel's beat with in_last=1 is accepted; other channels get in_ready=0 meanwhile, even if the locked channel drops in_valid.
REQ-029 SHALL, without ARB_MUX_PKT_LOCK_EN, re-arbitrate every beat, ignore in_last for arbitration, and still pass it through to out_last.

Structure
REQ-030 SHALL place in package arb_mux_pkg the default width/count constants and a function computing the next round-robin index.
REQ-031 SHALL implement the round-robin priority pick (requests, last_grant -> one-hot grant) as the single sub-module rr_pick.

Verification
REQ-032 Reset release with in_valid=4'b1111, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; out_sel follows one cycle later.
REQ-033 Only channel 2 valid, in_data ch2=32'hDEADBEEF -> out_data=32'hDEADBEEF, out_sel=2 one cycle after the grant; in_ready=4'b0100.
REQ-034 out_ready=0 for 3 cycles with out_valid=1 -> out_data stable and in_ready=0; on the first out_ready=1 cycle, simultaneous drain+load.
REQ-035 With ARB_MUX_PKT_LOCK_EN, ch1 sends 3 beats (in_last on the 3rd) while ch0/ch3 request -> ch1 gets 3 consecutive grants, then ch3, then ch0; without the macro -> ch1, ch3, ch0, ch1 interleaving.
REQ-036 rst_n pulsed low mid-packet with out_valid=1 -> out_valid=0 immediately (asynchronous); the next grant goes to the lowest requesting index.
